// File: rtl/vector_step_sequencer.sv
// Vector instruction step sequencer: issues a one-cycle CSR strobe for vsetvli and splits
// arithmetic instructions into per-register datapath steps with byte-lane tail masks.
module vector_step_sequencer #(
  parameter int unsigned VLENB  = 4,
  parameter int unsigned STEP_W = 3
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_is_config,
  input  logic [4:0]        vl,
  input  logic [1:0]        vsew,
  input  logic [1:0]        vlmul,
  output logic              csr_write,
  output logic              step_valid,
  input  logic              step_ready,
  output logic [STEP_W-1:0] step_reg_offset,
  output logic [VLENB-1:0]  step_byte_en,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [1:0] {StIdle, StConfig, StExec, StDone} state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [5:0]          remaining_q, remaining_d;
  logic [1:0]          sew_q, sew_d;
  logic [1:0]          lmul_q, lmul_d;
  logic                illegal_q, illegal_d;

  logic [5:0]          per_reg;
  logic [5:0]          active;
  logic [5:0]          bytes;
  logic [STEP_W-1:0]   last_idx;

  // Geometry uses only the values latched at accept, never the live CSR inputs.
  assign per_reg  = 6'(VLENB) >> sew_q;
  assign active   = (remaining_q < per_reg) ? remaining_q : per_reg;
  assign bytes    = active << sew_q;
  assign last_idx = STEP_W'((32'd1 << lmul_q) - 32'd1);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      step_q      <= '0;
      remaining_q <= '0;
      sew_q       <= '0;
      lmul_q      <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      sew_q       <= sew_d;
      lmul_q      <= lmul_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    step_d          = step_q;
    remaining_d     = remaining_q;
    sew_d           = sew_q;
    lmul_d          = lmul_q;
    illegal_d       = illegal_q;
    instr_ready     = 1'b0;
    csr_write       = 1'b0;
    step_valid      = 1'b0;
    step_reg_offset = '0;
    step_byte_en    = '0;
    done            = 1'b0;
    illegal         = 1'b0;

    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          sew_d       = vsew;
          lmul_d      = vlmul;
          illegal_d   = 1'b0;
          step_d      = '0;
          remaining_d = {1'b0, vl};
          if (instr_is_config) begin
            state_d = StConfig;
          end else if (vsew == 2'd3) begin
            state_d   = StDone;
            illegal_d = 1'b1;
          end else if (vl == 5'd0) begin
            state_d = StDone;
          end else begin
            state_d = StExec;
          end
        end
      end
      StConfig: begin
        csr_write = 1'b1;
        state_d   = StDone;
      end
      StExec: begin
        step_valid      = 1'b1;
        step_reg_offset = step_q;
        for (int i = 0; i < VLENB; i++) begin
          step_byte_en[i] = (6'(i) < bytes);
        end
        if (step_ready) begin
          step_d      = step_q + 1'b1;
          remaining_d = (remaining_q > per_reg) ? remaining_q - per_reg : 6'd0;
          if (remaining_q <= per_reg || step_q == last_idx) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        illegal = illegal_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_vector_step_sequencer.sv
// Directed self-checking bench for vector_step_sequencer with hand-computed expectations.
module tb_vector_step_sequencer;

  localparam int unsigned VLENB  = 4;
  localparam int unsigned STEP_W = 3;

  logic              clk;
  logic              n_reset;
  logic              instr_valid;
  logic              instr_ready;
  logic              instr_is_config;
  logic [4:0]        vl;
  logic [1:0]        vsew;
  logic [1:0]        vlmul;
  logic              csr_write;
  logic              step_valid;
  logic              step_ready;
  logic [STEP_W-1:0] step_reg_offset;
  logic [VLENB-1:0]  step_byte_en;
  logic              done;
  logic              illegal;

  int n_checks;
  int n_pass;

  vector_step_sequencer #(
    .VLENB (VLENB),
    .STEP_W(STEP_W)
  ) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_is_config(instr_is_config),
    .vl             (vl),
    .vsew           (vsew),
    .vlmul          (vlmul),
    .csr_write      (csr_write),
    .step_valid     (step_valid),
    .step_ready     (step_ready),
    .step_reg_offset(step_reg_offset),
    .step_byte_en   (step_byte_en),
    .done           (done),
    .illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic cfg, input logic [4:0] v, input logic [1:0] s,
                        input logic [1:0] l);
    instr_is_config = cfg;
    vl              = v;
    vsew            = s;
    vlmul           = l;
    instr_valid     = 1'b1;
    check("accept_ready", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic check_step(input string tag, input logic [STEP_W-1:0] off,
                            input logic [VLENB-1:0] be);
    check({tag, "_valid"}, 32'(step_valid), 32'd1);
    check({tag, "_off"}, 32'(step_reg_offset), 32'(off));
    check({tag, "_be"}, 32'(step_byte_en), 32'(be));
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic check_done(input string tag, input logic ill);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_illegal"}, 32'(illegal), 32'(ill));
    check({tag, "_sv"}, 32'(step_valid), 32'd0);
    check({tag, "_rdy"}, 32'(instr_ready), 32'd0);
    tick();
    check({tag, "_idle_rdy"}, 32'(instr_ready), 32'd1);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    n_checks        = 0;
    n_pass          = 0;
    n_reset         = 1'b0;
    instr_valid     = 1'b0;
    instr_is_config = 1'b0;
    vl              = '0;
    vsew            = '0;
    vlmul           = '0;
    step_ready      = 1'b1;

    // Reset state
    #12;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_csr", 32'(csr_write), 32'd0);
    check("rst_sv", 32'(step_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_be", 32'(step_byte_en), 32'd0);
    n_reset = 1'b1;
    tick();

    // Config: strobe at +1, done at +2, ready at +3
    accept(1'b1, 5'd7, 2'd0, 2'd0);
    check("cfg_csr1", 32'(csr_write), 32'd1);
    check("cfg_done1", 32'(done), 32'd0);
    check("cfg_rdy1", 32'(instr_ready), 32'd0);
    tick();
    check("cfg_csr2", 32'(csr_write), 32'd0);
    check_done("cfg", 1'b0);

    // vl=6, sew8, lmul2: 4 + 2 elements
    step_ready = 1'b1;
    accept(1'b0, 5'd6, 2'd0, 2'd1);
    check_step("a0", 3'd0, 4'b1111);
    tick();
    check_step("a1", 3'd1, 4'b0011);
    tick();
    check_done("a", 1'b0);

    // vl=5, sew16, lmul4, stall on step 1 for two cycles
    accept(1'b0, 5'd5, 2'd1, 2'd2);
    check_step("b0", 3'd0, 4'b1111);
    tick();
    step_ready = 1'b0;
    check_step("b1", 3'd1, 4'b1111);
    tick();
    check_step("b1s1", 3'd1, 4'b1111);
    tick();
    check_step("b1s2", 3'd1, 4'b1111);
    step_ready = 1'b1;
    tick();
    check_step("b2", 3'd2, 4'b0011);
    tick();
    check_done("b", 1'b0);

    // vl=31, sew32, lmul8: capped at 8 steps; live inputs changed mid-flight
    accept(1'b0, 5'd31, 2'd2, 2'd3);
    vl    = 5'd1;
    vsew  = 2'd0;
    vlmul = 2'd0;
    for (int i = 0; i < 8; i++) begin
      check_step($sformatf("c%0d", i), STEP_W'(i), 4'b1111);
      tick();
    end
    check_done("c", 1'b0);

    // vl=0: immediate done, no steps
    accept(1'b0, 5'd0, 2'd0, 2'd1);
    check_done("vl0", 1'b0);

    // vsew=3: illegal abort
    accept(1'b0, 5'd5, 2'd3, 2'd1);
    check_done("ill", 1'b1);

    // Reset mid-EXEC drops step_valid asynchronously and suppresses done
    accept(1'b0, 5'd31, 2'd2, 2'd3);
    check("mid_sv_pre", 32'(step_valid), 32'd1);
    #2;
    n_reset = 1'b0;
    #1;
    check("mid_sv_async", 32'(step_valid), 32'd0);
    check("mid_rdy_async", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_done%0d", i), 32'(done), 32'd0);
    end
    n_reset = 1'b1;
    tick();
    check("mid_after_done", 32'(done), 32'd0);
    check("mid_after_sv", 32'(step_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_step_sequencer.md
Name: vector_step_sequencer

Overview:
- Accepts one decoded vector instruction at a time from the APU interface front end.
- Config instructions (vsetvli) get a single-cycle CSR write strobe.
- Arithmetic instructions are broken into per-register micro-steps over the LMUL register group, using the current vl/vsew/vlmul. Each step carries a byte-enable tail mask.
- Sits between the APU interface FSM, the vector CSR block and the vector datapath. It is the only source of the CSR write strobe and of datapath step requests.

Parameters:
- VLENB, 4, vector register length in bytes (power of 2); elements per register = VLENB >> vsew.
- STEP_W, 3, width of step counter; max steps = 2**STEP_W (LMUL=8).

Ports:
- clk  input  1  clock, all state on rising edge
- n_reset  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction offered by APU front end
- instr_ready  output  1  sequencer can accept; high only in IDLE
- instr_is_config  input  1  offered instruction is vsetvli
- vl  input  5  current vector length from CSR block
- vsew  input  2  current element width code (0=8b, 1=16b, 2=32b, 3=reserved)
- vlmul  input  2  current LMUL code (register group = 1<<vlmul)
- csr_write  output  1  one-cycle write strobe to CSR block
- step_valid  output  1  datapath step request
- step_ready  input  1  datapath accepts step
- step_reg_offset  output  STEP_W  register index offset within group for this step
- step_byte_en  output  VLENB  active byte lanes for this step
- done  output  1  one-cycle completion pulse to APU front end
- illegal  output  1  qualifies done: instruction aborted (vsew==3)

Behaviour:
- Reset (async, any state): state=IDLE; counters=0; instr_ready=1; all other outputs 0.
- Acceptance: handshake on instr_valid & instr_ready. On that edge latch instr_is_config, vl, vsew, vlmul. Later CSR changes do not affect the instruction in flight.
- States: IDLE, CONFIG, EXEC, DONE.
- IDLE -> CONFIG on accept with is_config=1.
- IDLE -> DONE on accept with is_config=0 and (vl==0 or vsew==3). illegal=1 in DONE only for vsew==3.
- IDLE -> EXEC on accept otherwise. Initialise step=0 and remaining=vl (6-bit).
- CONFIG: csr_write=1 for exactly one cycle, then -> DONE. The CSRs update at that edge, so the next instruction accepted sees the new vl.
- EXEC: step_valid=1 and step_reg_offset=step.
  - step_valid and step_reg_offset are held stable until step_ready.
  - On a step_valid & step_ready edge: step+=1; remaining -= per_reg (saturate at 0).
  - Go to DONE when the step just accepted had remaining <= per_reg, or when step == (1<<vlmul)-1.
  - Step count is therefore min(ceil(vl/per_reg), 1<<vlmul).
- step_byte_en: active = min(remaining, per_reg). Bytes enabled = active << vsew. Set lowest bytes first; e.g. vsew=1, active=1 -> 4'b0011.
- DONE: done=1 for one cycle, then -> IDLE. instr_ready=0 in DONE, so back-to-back instructions are spaced at least 1 cycle.
- Latency from accept to done:
  - config: 2 cycles.
  - vl==0 or illegal: 1 cycle.
  - exec: N steps with step_ready always high = N+1 cycles.
- step_ready while step_valid=0 is ignored. instr_valid outside IDLE is ignored and not queued.
- Reset asserted mid-EXEC: step_valid drops immediately; no done is produced.

Test Plan:
- Reset then idle: instr_ready=1; csr_write, step_valid, done, illegal all 0; holding n_reset low mid-EXEC forces step_valid=0 asynchronously.
- Config: accept is_config=1 -> csr_write high on cycle +1 only, done on cycle +2, instr_ready back high on cycle +3.
- vl=6, vsew=0 (per_reg=4), vlmul=1, step_ready=1 -> two steps: offset 0 byte_en 1111, then offset 1 byte_en 0011; done one cycle after the second step.
- vl=5, vsew=1 (per_reg=2), vlmul=2, step_ready stalled 2 cycles on step 1 -> offsets 0,1,2 with byte_en 1111, 1111, 0011; offset 1 and its byte_en held constant through the stall.
- vl=31, vsew=2, vlmul=3 -> capped at 8 steps, each with byte_en 1111, then done. Changing the vl input mid-EXEC changes nothing.
- vl=0 -> done on cycle +1, no step_valid. vsew=3 -> done and illegal together on cycle +1, no steps.
